prog_counter: RTL

Parametrised programmable counter/timer, successor to the fixed 4-bit counter. It counts up or down from a loaded initial value by a programmable step until it reaches a target. It runs either one-shot or auto-reload, with a start/stop/busy/done handshake and a period counter. It is used as the reusable sequencing/timeout primitive for datapath controllers.

---
 rtl/prog_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/prog_counter.sv
// Programmable up/down counter/timer with one-shot or auto-reload sequencing,
// start/stop handshake, done/error pulses and a saturating period counter.
module prog_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              enable_i,
  input  logic              dir_i,
  input  logic              mode_i,
  input  logic [WIDTH-1:0]  init_i,
  input  logic [WIDTH-1:0]  step_i,
  input  logic [WIDTH-1:0]  target_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [PCNT_W-1:0] periods_o
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WRAP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Configuration captured when a start is accepted
  logic             dir_q,    dir_d;
  logic             mode_q,   mode_d;
  logic [WIDTH-1:0] init_q,   init_d;
  logic [WIDTH-1:0] step_q,   step_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic [WIDTH-1:0]  count_d;
  logic              busy_d;
  logic              done_d;
  logic              error_d;
  logic [PCNT_W-1:0] periods_d;

  logic [EXT_W-1:0] sum_c;
  logic [EXT_W-1:0] diff_c;
  logic [WIDTH-1:0] nxt_c;
  logic             reached_c;
  logic [PCNT_W-1:0] periods_inc_c;

  // One extra bit catches overflow (up) or borrow (down) so the count clamps at target
  always_comb begin
    sum_c  = {1'b0, count_o} + {1'b0, step_q};
    diff_c = {1'b0, count_o} - {1'b0, step_q};
    if (dir_q) begin
      nxt_c     = diff_c[WIDTH-1:0];
      reached_c = diff_c[WIDTH] || (diff_c[WIDTH-1:0] <= target_q);
    end else begin
      nxt_c     = sum_c[WIDTH-1:0];
      reached_c = (sum_c >= {1'b0, target_q});
    end
  end

  assign periods_inc_c = (periods_o == PCNT_MAX) ? periods_o : periods_o + PCNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    init_d    = init_q;
    step_d    = step_q;
    target_d  = target_q;
    count_d   = count_o;
    done_d    = 1'b0;
    error_d   = 1'b0;
    periods_d = periods_o;

    unique case (state_q)
      IDLE: begin
        // A simultaneous stop cancels the start outright, including the step check
        if (start_i && !stop_i) begin
          if (step_i == '0) begin
            error_d = 1'b1;
          end else begin
            dir_d     = dir_i;
            mode_d    = mode_i;
            init_d    = init_i;
            step_d    = step_i;
            target_d  = target_i;
            count_d   = init_i;
            periods_d = '0;
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (enable_i) begin
          if (reached_c) begin
            count_d   = target_q;
            done_d    = 1'b1;
            periods_d = periods_inc_c;
            state_d   = mode_q ? WRAP : IDLE;
          end else begin
            count_d = nxt_c;
          end
        end
      end

      WRAP: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          count_d = init_q;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, configuration and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      init_q    <= '0;
      step_q    <= '0;
      target_q  <= '0;
      count_o   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      periods_o <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      init_q    <= init_d;
      step_q    <= step_d;
      target_q  <= target_d;
      count_o   <= count_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      error_o   <= error_d;
      periods_o <= periods_d;
    end
  end

endmodule
